// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding buffer per execution unit, round-robin broadcast of one result per cycle.
// Optional same-cycle bypass when every buffer is empty: define CDB_ARB_BYPASS_EN.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [NUM_REQ-1:0]        cdb_grant,
    output logic [(2**TAG_W)-1:0]     set_rob_valid
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] buf_valid_q, buf_valid_d;
    logic [TAG_W-1:0]   buf_tag_q  [NUM_REQ];
    logic [TAG_W-1:0]   buf_tag_d  [NUM_REQ];
    logic [DATA_W-1:0]  buf_data_q [NUM_REQ];
    logic [DATA_W-1:0]  buf_data_d [NUM_REQ];
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [TAG_W-1:0]   in_tag_s  [NUM_REQ];
    logic [DATA_W-1:0]  in_data_s [NUM_REQ];
    logic [NUM_REQ-1:0] cand_s;
    logic [PTR_W-1:0]   idx_s;
    logic [PTR_W-1:0]   grant_idx_s;
    logic               grant_any_s;
    logic               bypass_s;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            in_tag_s[i]  = req_tag[i*TAG_W +: TAG_W];
            in_data_s[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin search from rr_ptr; live requests compete only when bypass is built in and all buffers are empty.
    always_comb begin
        bypass_s    = 1'b0;
        cand_s      = buf_valid_q;
`ifdef CDB_ARB_BYPASS_EN
        if (buf_valid_q == '0) begin
            bypass_s = 1'b1;
            cand_s   = req_valid;
        end else begin
            bypass_s = 1'b0;
            cand_s   = buf_valid_q;
        end
`endif
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        idx_s       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_any_s && cand_s[idx_s]) begin
                grant_any_s = 1'b1;
                grant_idx_s = idx_s;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
        if (rst || flush) begin
            grant_any_s = 1'b0;
        end else begin
            grant_any_s = grant_any_s;
        end
    end

    // Bus drive, grant vector, ROB valid decode and per-unit ready.
    always_comb begin
        cdb_valid     = grant_any_s;
        cdb_tag       = '0;
        cdb_data      = '0;
        cdb_grant     = '0;
        set_rob_valid = '0;
        if (grant_any_s) begin
            cdb_grant[grant_idx_s] = 1'b1;
            if (bypass_s) begin
                cdb_tag  = in_tag_s[grant_idx_s];
                cdb_data = in_data_s[grant_idx_s];
            end else begin
                cdb_tag  = buf_tag_q[grant_idx_s];
                cdb_data = buf_data_q[grant_idx_s];
            end
            set_rob_valid[cdb_tag] = 1'b1;
        end else begin
            cdb_valid = 1'b0;
        end
        if (rst || flush) begin
            req_ready = '0;
        end else begin
            req_ready = ~buf_valid_q | cdb_grant;
        end
    end

    // Buffer drain/refill and pointer advance; flush wipes buffers but leaves the pointer alone.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (flush) begin
            buf_valid_d = '0;
        end else begin
            if (grant_any_s) begin
                buf_valid_d[grant_idx_s] = 1'b0;
                if (grant_idx_s == PTR_W'(NUM_REQ - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = grant_idx_s + 1'b1;
                end
            end else begin
                rr_ptr_d = rr_ptr_q;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                // A bypassed winner is already on the bus and must not also be buffered.
                if (req_valid[i] && req_ready[i] && !(bypass_s && cdb_grant[i])) begin
                    buf_valid_d[i] = 1'b1;
                    buf_tag_d[i]   = in_tag_s[i];
                    buf_data_d[i]  = in_data_s[i];
                end else begin
                    buf_valid_d[i] = buf_valid_d[i];
                end
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= '0;
            buf_tag_q   <= '{default: '0};
            buf_data_q  <= '{default: '0};
            rr_ptr_q    <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (default build, bypass disabled).
module tb_cdb_arbiter;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [3:0]   req_valid;
    logic [11:0]  req_tag;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         cdb_valid;
    logic [2:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic [3:0]   cdb_grant;
    logic [7:0]   set_rob_valid;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.NUM_REQ(4), .TAG_W(3), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
        .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_grant(cdb_grant), .set_rob_valid(set_rob_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic put(input int i, input logic [2:0] t, input logic [31:0] d);
        req_valid[i]       = 1'b1;
        req_tag[i*3 +: 3]  = t;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic bus(input string name, input logic v, input logic [3:0] g,
                       input logic [2:0] t, input logic [31:0] d, input logic [7:0] rob);
        chk({name, ".valid"}, 64'(cdb_valid), 64'(v));
        chk({name, ".grant"}, 64'(cdb_grant), 64'(g));
        chk({name, ".tag"},   64'(cdb_tag),   64'(t));
        chk({name, ".data"},  64'(cdb_data),  64'(d));
        chk({name, ".rob"},   64'(set_rob_valid), 64'(rob));
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; req_valid = 4'h0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 4'h0; req_tag = 12'h000; req_data = 128'h0;
        #1;
        settle();
        chk("rst_ready_low", 64'(req_ready), 64'h0);
        chk("rst_bus_idle", 64'(cdb_valid), 64'h0);
        tick(); tick();
        rst = 1'b0;
        settle();
        bus("after_rst", 1'b0, 4'h0, 3'd0, 32'h0, 8'h00);
        chk("after_rst_ready", 64'(req_ready), 64'hF);
        chk("after_rst_ptr", 64'(dut.rr_ptr_q), 64'h0);

        // Single request: unit 2, tag 5
        put(2, 3'd5, 32'h0000_00AB);
        settle();
        chk("single_no_bypass", 64'(cdb_valid), 64'h0);
        tick();
        req_valid = 4'h0;
        settle();
        bus("single", 1'b1, 4'b0100, 3'd5, 32'hAB, 8'b0010_0000);
        chk("single_ready", 64'(req_ready), 64'hF);
        tick();
        settle();
        chk("single_idle", 64'(cdb_valid), 64'h0);

        // Round-robin from pointer 0
        do_reset();
        for (int i = 0; i < 4; i++) put(i, 3'(i), 32'h10 + 32'(i));
        tick();
        req_valid = 4'h0;
        settle();
        bus("rr0", 1'b1, 4'b0001, 3'd0, 32'h10, 8'h01);
        chk("rr0_ready", 64'(req_ready), 64'b0001);
        tick(); settle();
        bus("rr1", 1'b1, 4'b0010, 3'd1, 32'h11, 8'h02);
        chk("rr1_ready", 64'(req_ready), 64'b0011);
        tick(); settle();
        bus("rr2", 1'b1, 4'b0100, 3'd2, 32'h12, 8'h04);
        chk("rr2_ready", 64'(req_ready), 64'b0111);
        tick(); settle();
        bus("rr3", 1'b1, 4'b1000, 3'd3, 32'h13, 8'h08);
        chk("rr3_ready", 64'(req_ready), 64'b1111);
        tick(); settle();
        chk("rr_idle", 64'(cdb_valid), 64'h0);

        // Fairness/refill: units 0 and 1 present every cycle
        put(0, 3'd4, 32'hA0);
        put(1, 3'd5, 32'hA1);
        tick(); settle();
        chk("fair1_grant", 64'(cdb_grant), 64'b0001);
        chk("fair1_ready", 64'(req_ready[1:0]), 64'b01);
        tick(); settle();
        chk("fair2_grant", 64'(cdb_grant), 64'b0010);
        chk("fair2_ready", 64'(req_ready[1:0]), 64'b10);
        tick(); settle();
        chk("fair3_grant", 64'(cdb_grant), 64'b0001);
        chk("fair3_ready", 64'(req_ready[1:0]), 64'b01);
        tick(); settle();
        chk("fair4_grant", 64'(cdb_grant), 64'b0010);
        chk("fair4_tag", 64'(cdb_tag), 64'd5);
        tick();
        req_valid = 4'h0;
        settle();
        chk("fair5_grant", 64'(cdb_grant), 64'b0001);
        tick(); settle();
        chk("fair6_grant", 64'(cdb_grant), 64'b0010);
        tick(); settle();
        chk("fair_idle", 64'(cdb_valid), 64'h0);

        // Flush with tags 1,4,6 buffered; tag 7 in flush cycle dropped
        put(0, 3'd1, 32'h01);
        put(1, 3'd4, 32'h04);
        put(2, 3'd6, 32'h06);
        tick();
        req_valid = 4'h0;
        flush = 1'b1;
        put(3, 3'd7, 32'h70);
        settle();
        bus("flush_cycle", 1'b0, 4'h0, 3'd0, 32'h0, 8'h00);
        chk("flush_ready", 64'(req_ready), 64'h0);
        tick();
        flush = 1'b0;
        req_valid = 4'h0;
        put(3, 3'd7, 32'h77);
        settle();
        chk("post_flush_idle", 64'(cdb_valid), 64'h0);
        chk("post_flush_ready", 64'(req_ready), 64'hF);
        tick();
        req_valid = 4'h0;
        settle();
        bus("post_flush_t7", 1'b1, 4'b1000, 3'd7, 32'h77, 8'h80);
        tick(); settle();
        chk("post_flush_drained", 64'(cdb_valid), 64'h0);

        // Reset mid-operation with rr_ptr = 2 and two buffers valid
        put(1, 3'd3, 32'h31);
        tick();
        req_valid = 4'h0;
        settle();
        chk("mid_pre_grant", 64'(cdb_grant), 64'b0010);
        tick();
        put(0, 3'd2, 32'h20);
        put(3, 3'd6, 32'h36);
        tick();
        req_valid = 4'h0;
        settle();
        chk("mid_ptr2_grant", 64'(cdb_grant), 64'b1000);
        rst = 1'b1;
        settle();
        chk("mid_rst_bus", 64'(cdb_valid), 64'h0);
        chk("mid_rst_ready", 64'(req_ready), 64'h0);
        tick();
        rst = 1'b0;
        settle();
        bus("mid_after_rst", 1'b0, 4'h0, 3'd0, 32'h0, 8'h00);
        chk("mid_after_rst_ready", 64'(req_ready), 64'hF);
        chk("mid_after_rst_ptr", 64'(dut.rr_ptr_q), 64'h0);
        put(1, 3'd1, 32'h11);
        put(3, 3'd5, 32'h35);
        tick();
        req_valid = 4'h0;
        settle();
        bus("mid_g1", 1'b1, 4'b0010, 3'd1, 32'h11, 8'h02);
        tick(); settle();
        bus("mid_g3", 1'b1, 4'b1000, 3'd5, 32'h35, 8'h20);
        tick(); settle();
        chk("mid_idle", 64'(cdb_valid), 64'h0);

        // Back-pressure on unit 3
        put(0, 3'd0, 32'h40);
        put(1, 3'd1, 32'h41);
        put(3, 3'd2, 32'h32);
        tick();
        req_valid = 4'h0;
        put(3, 3'd2, 32'h99);
        settle();
        chk("bp1_grant", 64'(cdb_grant), 64'b0001);
        chk("bp1_ready3", 64'(req_ready[3]), 64'h0);
        tick(); settle();
        chk("bp2_grant", 64'(cdb_grant), 64'b0010);
        chk("bp2_ready3", 64'(req_ready[3]), 64'h0);
        tick(); settle();
        bus("bp3", 1'b1, 4'b1000, 3'd2, 32'h32, 8'h04);
        chk("bp3_ready3", 64'(req_ready[3]), 64'h1);
        tick();
        req_valid = 4'h0;
        settle();
        bus("bp4", 1'b1, 4'b1000, 3'd2, 32'h99, 8'h04);
        tick(); settle();
        chk("bp_idle", 64'(cdb_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
